// File: rtl/fc_weight_slice_streamer.sv
// Captures a NUM_OUT x NUM_TAP weight set in one beat and streams it as SLICE-wide column slices.
// Optional double buffering (shadow bank + swap) is enabled by defining FC_WBUF_PINGPONG_EN.
module fc_weight_slice_streamer #(
    parameter int unsigned NUM_OUT = 10,
    parameter int unsigned NUM_TAP = 9,
    parameter int unsigned SLICE   = 3,
    parameter int unsigned WIDTH   = 8,
    localparam int unsigned NUM_SLICE = (NUM_TAP + SLICE - 1) / SLICE,
    localparam int unsigned IDX_W     = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1,
    localparam int unsigned BANK_W    = NUM_OUT * NUM_TAP * WIDTH,
    localparam int unsigned SLICE_W   = NUM_OUT * SLICE * WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_valid,
    output logic               o_load_ready,
    input  logic [BANK_W-1:0]  i_load_weight,
    input  logic               i_start,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [SLICE_W-1:0] o_weight,
    output logic [IDX_W-1:0]   o_slice_idx,
    output logic               o_last,
    output logic               o_busy
);

    typedef enum logic [1:0] {StEmpty, StReady, StStream} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic               load_acc;
    logic               hs;
    logic               last_slice;
    logic               fill_done;

    assign hs         = (state_q == StStream) && i_ready;
    assign last_slice = (cnt_q == IDX_W'(NUM_SLICE - 1));
    assign load_acc   = i_load_valid && o_load_ready;

`ifdef FC_WBUF_PINGPONG_EN
    logic [BANK_W-1:0] shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              swap;

    // Idle banks promote a filled shadow at once; a streaming bank waits for its last slice.
    assign swap      = !i_flush && shadow_full_q &&
                       ((state_q != StStream) || (hs && last_slice));
    assign fill_done = swap;

    always_comb begin
        bank_d        = swap ? shadow_q : bank_q;
        shadow_d      = load_acc ? i_load_weight : shadow_q;
        shadow_full_d = shadow_full_q;
        if (i_flush) begin
            shadow_full_d = 1'b0;
        end else if (load_acc) begin
            shadow_full_d = 1'b1;
        end else if (swap) begin
            shadow_full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bank_q        <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
        end
    end
`else
    assign fill_done = load_acc;

    always_comb begin
        bank_d = load_acc ? i_load_weight : bank_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = StEmpty;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (fill_done) begin
                        state_d = StReady;
                    end
                end
                StReady: begin
                    if (i_start) begin
                        state_d = StStream;
                        cnt_d   = '0;
                    end
                end
                StStream: begin
                    if (hs) begin
                        if (last_slice) begin
                            state_d = StReady;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StEmpty;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_busy  = 1'b0;
        o_last  = 1'b0;
        if (state_q == StStream) begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            o_last  = last_slice;
        end
`ifdef FC_WBUF_PINGPONG_EN
        o_load_ready = !i_flush && !shadow_full_q;
`else
        o_load_ready = !i_flush && (state_q != StStream);
`endif
    end

    assign o_slice_idx = cnt_q;

    // Columns past NUM_TAP in a ragged last slice read as zero.
    always_comb begin
        o_weight = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            for (int j = 0; j < SLICE; j++) begin
                if ((int'(cnt_q) * SLICE + j) < NUM_TAP) begin
                    o_weight[(i * SLICE + j) * WIDTH +: WIDTH] =
                        bank_q[(i * NUM_TAP + int'(cnt_q) * SLICE + j) * WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_weight_slice_streamer.sv
// Self-checking bench for fc_weight_slice_streamer: vector table plus slice scoreboard.
// Build with FC_WBUF_PINGPONG_EN defined to exercise the double-buffered variant.
module tb_fc_weight_slice_streamer;

    localparam int NO  = 10;
    localparam int NT  = 9;
    localparam int SL  = 3;
    localparam int W   = 8;
    localparam int NS  = 3;
    localparam int BW  = NO * NT * W;
    localparam int SW  = NO * SL * W;
    localparam int NT2 = 10;
    localparam int SL2 = 4;
    localparam int BW2 = NO * NT2 * W;
    localparam int SW2 = NO * SL2 * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          load_valid = 1'b0, load_ready;
    logic [BW-1:0] load_weight = '0;
    logic          start = 1'b0, flush = 1'b0, ready = 1'b0;
    logic          valid, last, busy;
    logic [SW-1:0] weight;
    logic [1:0]    idx;

    logic           load_valid2 = 1'b0, load_ready2;
    logic [BW2-1:0] load_weight2 = '0;
    logic           start2 = 1'b0, ready2 = 1'b0;
    logic           valid2, last2, busy2;
    logic [SW2-1:0] weight2;
    logic [1:0]     idx2;

    fc_weight_slice_streamer #(.NUM_OUT(NO), .NUM_TAP(NT), .SLICE(SL), .WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid), .o_load_ready(load_ready),
        .i_load_weight(load_weight), .i_start(start), .i_flush(flush), .o_valid(valid),
        .i_ready(ready), .o_weight(weight), .o_slice_idx(idx), .o_last(last), .o_busy(busy)
    );

    fc_weight_slice_streamer #(.NUM_OUT(NO), .NUM_TAP(NT2), .SLICE(SL2), .WIDTH(W)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid2), .o_load_ready(load_ready2),
        .i_load_weight(load_weight2), .i_start(start2), .i_flush(1'b0), .o_valid(valid2),
        .i_ready(ready2), .o_weight(weight2), .o_slice_idx(idx2), .o_last(last2),
        .o_busy(busy2)
    );

    typedef struct {
        logic [1:0]    idx;
        logic [SW-1:0] w;
    } exp_t;

    typedef struct {
        logic       start;
        logic       rdy;
        logic       v;
        logic       lst;
        logic [1:0] idx;
    } vec_t;

    exp_t          exp_q[$];
    vec_t          vt[12];
    logic [BW-1:0] mbank = '0;
    logic [BW-1:0] mshadow = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [BW-1:0] pat(input logic [7:0] base);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < NO; i++)
            for (int j = 0; j < NT; j++)
                v[(i * NT + j) * W +: W] = 8'(i * 16 + j) ^ base;
        return v;
    endfunction

    function automatic logic [SW-1:0] slice_of(input logic [BW-1:0] b, input int s);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < NO; i++)
            for (int j = 0; j < SL; j++)
                if (s * SL + j < NT) r[(i * SL + j) * W +: W] = b[(i * NT + s * SL + j) * W +: W];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [SW2-1:0] act, input logic [SW2-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push_stream();
        for (int k = 0; k < NS; k++) exp_q.push_back('{idx: 2'(k), w: slice_of(mbank, k)});
    endtask

    // Scoreboard monitor runs mid-cycle; a slice is retired only on a handshake.
    task automatic tick();
        @(negedge clk);
        if (valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_slice: actual idx %0d required no slice", idx);
            end else begin
                chk("sb_idx", SW2'(idx), SW2'(exp_q[0].idx));
                chk("sb_data", SW2'(weight), SW2'(exp_q[0].w));
                if (ready) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [BW-1:0] d);
        chk("load_ready_idle", SW2'(load_ready), SW2'(1'b1));
        load_weight = d;
        load_valid  = 1'b1;
        tick();
        load_valid = 1'b0;
        mbank      = d;
        tick();
    endtask

    task automatic run_stream();
        start = 1'b1;
        push_stream();
        tick();
        start = 1'b0;
        ready = 1'b1;
        repeat (NS) tick();
        ready = 1'b0;
        chk("stream_end_valid", SW2'(valid), SW2'(1'b0));
        chk("stream_drained", SW2'(exp_q.size()), SW2'(0));
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", SW2'(valid), SW2'(1'b0));
        chk("rst_last", SW2'(last), SW2'(1'b0));
        chk("rst_busy", SW2'(busy), SW2'(1'b0));
        chk("rst_load_ready", SW2'(load_ready), SW2'(1'b1));
        chk("rst_idx", SW2'(idx), SW2'(0));
        chk("rst_weight", SW2'(weight), SW2'(0));

        // Start before any load must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_ignored", SW2'(valid), SW2'(1'b0));

        // Single stream, then a stalled stream reusing the bank without reload.
        load(pat(8'h00));
        for (int k = 0; k < 12; k++) begin
            start = vt[k].start;
            ready = vt[k].rdy;
            if (vt[k].start) push_stream();
            #2;
            chk("vec_valid", SW2'(valid), SW2'(vt[k].v));
            chk("vec_busy", SW2'(busy), SW2'(vt[k].v));
            chk("vec_last", SW2'(last), SW2'(vt[k].lst));
            chk("vec_idx", SW2'(idx), SW2'(vt[k].idx));
            if (k == 2) chk("slice1_row3", SW2'(weight[9 * W +: 24]), SW2'(24'h353433));
            tick();
        end
        start = 1'b0;
        ready = 1'b0;
        chk("vec_drained", SW2'(exp_q.size()), SW2'(0));

        // Ragged last slice on the 10-tap, 4-wide instance.
        load_weight2 = '1;
        load_valid2  = 1'b1;
        tick();
        load_valid2 = 1'b0;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ready2 = 1'b1;
        for (int s = 0; s < 3; s++) begin
            logic [31:0] rp;
            rp = (s == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            chk("pad_valid", SW2'(valid2), SW2'(1'b1));
            chk("pad_idx", SW2'(idx2), SW2'(s));
            chk("pad_last", SW2'(last2), SW2'(s == 2));
            chk("pad_weight", weight2, {NO{rp}});
            tick();
        end
        ready2 = 1'b0;
        chk("pad_end_valid", SW2'(valid2), SW2'(1'b0));

        // Flush on the idx-1 handshake with a competing load.
        load(pat(8'h5A));
        start = 1'b1;
        push_stream();
        tick();
        start = 1'b0;
        ready = 1'b1;
        tick();
        flush       = 1'b1;
        load_valid  = 1'b1;
        load_weight = pat(8'hA5);
        chk("flush_load_ready", SW2'(load_ready), SW2'(1'b0));
        tick();
        flush      = 1'b0;
        load_valid = 1'b0;
        exp_q.delete();
        chk("flush_valid", SW2'(valid), SW2'(1'b0));
        chk("flush_busy", SW2'(busy), SW2'(1'b0));
        chk("flush_idx", SW2'(idx), SW2'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("flush_start_ignored", SW2'(valid), SW2'(1'b0));
        tick();
        ready = 1'b0;
        chk("flush_still_empty", SW2'(valid), SW2'(1'b0));

        load(pat(8'h3C));
`ifdef FC_WBUF_PINGPONG_EN
        // Load B into the shadow during A, third load stalls, then B streams.
        start = 1'b1;
        push_stream();
        tick();
        start = 1'b0;
        ready = 1'b1;
        tick();
        load_valid  = 1'b1;
        load_weight = pat(8'h81);
        chk("pp_load_ready_stream", SW2'(load_ready), SW2'(1'b1));
        tick();
        mshadow     = pat(8'h81);
        load_weight = pat(8'h42);
        chk("pp_third_load_stall", SW2'(load_ready), SW2'(1'b0));
        tick();
        load_valid = 1'b0;
        ready      = 1'b0;
        mbank      = mshadow;
        chk("pp_after_swap_ready", SW2'(load_ready), SW2'(1'b1));
        chk("pp_after_swap_valid", SW2'(valid), SW2'(1'b0));
        chk("pp_a_drained", SW2'(exp_q.size()), SW2'(0));
        run_stream();
`else
        // Loads are refused for the whole stream and taken right after it.
        start = 1'b1;
        push_stream();
        tick();
        start       = 1'b0;
        load_valid  = 1'b1;
        load_weight = pat(8'hC3);
        chk("sb_load_ready_stall", SW2'(load_ready), SW2'(1'b0));
        tick();
        ready = 1'b1;
        for (int k = 0; k < NS; k++) begin
            chk("sb_load_ready_stream", SW2'(load_ready), SW2'(1'b0));
            tick();
        end
        chk("sb_load_ready_after", SW2'(load_ready), SW2'(1'b1));
        chk("sb_valid_after", SW2'(valid), SW2'(1'b0));
        tick();
        load_valid = 1'b0;
        ready      = 1'b0;
        mbank      = pat(8'hC3);
        chk("sb_drained", SW2'(exp_q.size()), SW2'(0));
        run_stream();
`endif

        // Reset in the middle of a stream.
        start = 1'b1;
        push_stream();
        tick();
        start = 1'b0;
        ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        exp_q.delete();
        chk("midrst_valid", SW2'(valid), SW2'(1'b0));
        chk("midrst_last", SW2'(last), SW2'(1'b0));
        chk("midrst_busy", SW2'(busy), SW2'(1'b0));
        chk("midrst_idx", SW2'(idx), SW2'(0));
        chk("midrst_weight", SW2'(weight), SW2'(0));
        chk("midrst_load_ready", SW2'(load_ready), SW2'(1'b1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midrst_start_ignored", SW2'(valid), SW2'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
